mult8_seq_ctrl: RTL and testbench
=================================

# mult8_seq_ctrl

Sequential controller that computes an 8×8 unsigned product by time-multiplexing one external 2×2 multiplier core over all 16 digit-pair partial products and shift-accumulating them. It sits between a valid/ready operand source and a valid/ready result sink. Any generated 2×2 core variant, exact or approximate/corrected, can be plugged in unchanged, so wider multipliers are built from the same small core.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 2, core operand width.
- N_DIG, WIDTH/DIGIT (4), digits per operand; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  controller can accept operands.
- a  in  WIDTH  multiplicand, sampled on accept.
- b  in  WIDTH  multiplier, sampled on accept.
- core_a  out  DIGIT  digit of a driven to the core.
- core_b  out  DIGIT  digit of b driven to the core.
- core_p  in  2*DIGIT  combinational core product, unsigned.
- out_valid  out  1  result available.
- out_ready  in  1  sink accepts result.
- p  out  2*WIDTH  accumulated product.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a and b into a_reg and b_reg, clear acc, set i=0 and j=0, go to RUN.
- RUN:
  - in_ready=0.
  - core_a = a_reg[DIGIT*i +: DIGIT].
  - core_b = b_reg[DIGIT*j +: DIGIT].
  - Each cycle: acc <= acc + (zero-extended core_p << DIGIT*(i+j)), truncated to 2*WIDTH bits, so wrap-around is modulo 2^16.
  - Index order: j increments fastest; when j wraps from N_DIG-1 to 0, i increments.
  - After the accumulation with i=j=N_DIG-1, go to DONE.
- DONE:
  - out_valid=1 and p=acc.
  - Hold until out_ready=1, then go to IDLE.
  - out_valid stays asserted and p stays stable while out_ready=0.
- p always reflects acc. Its value is meaningful only while out_valid=1.
- Outside RUN, core_a and core_b are driven with 0.
- core_p is consumed as-is with no correction. Approximate cores yield approximate products by design.
- in_valid while not in IDLE is ignored. The source must hold it, and a and b must stay stable until in_ready=1.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, p=0, core_a=0, core_b=0, i=j=0.
- Accept edge T0 leads to RUN for cycles T0+1 … T0+16, one partial product per cycle, 16 accumulations in total.
- out_valid rises after edge T0+16; latency from accept to out_valid is 16 cycles.
- The result handshake completes on the edge where out_valid&out_ready. in_ready returns to 1 on the next cycle; there is no same-cycle bypass.
- Minimum initiation interval is 18 cycles.
- Reset asserted mid-RUN or in DONE: immediate return to reset values, the in-flight operation is discarded, and no out_valid pulse occurs.
- The core path is combinational within one cycle, so the core must meet single-cycle timing together with the adder.

## Structure
- Package mult_seq_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - constants DIGIT_W=2, N_DIG=4, ACC_W=16.
- Sub-module mult_seq_acc contains the shift-accumulate register: inputs clr, en, shamt, pp; output acc.
- The FSM and digit counters stay in mult8_seq_ctrl.
- The 2×2 core is instantiated by the parent, not inside this block.

## Test plan
- Exact-core model, a=0x12, b=0x34 -> out_valid 16 cycles after accept, p=936 (0x03A8).
- Exact core, a=0xFF, b=0xFF -> p=65025 (0xFE01); a=0x00, b=0xA5 -> p=0.
- Core stub returning constant 4'hF, any operands -> p=108375 mod 65536 = 42839 (0xA757), which checks the shift amounts and the wrap.
- Back-to-back: in_valid held high with two operand pairs, out_ready=1 -> second accept exactly 18 cycles after the first, and in_ready=0 throughout RUN and DONE.
- out_ready held low 5 cycles after out_valid -> p and out_valid stable for all 5 cycles, and in_ready stays 0.
- rst_n pulsed low at RUN cycle 7 -> outputs at reset values immediately; a following a=3, b=3 operation yields p=9 with the exact core.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared types and sizing for the digit-serial multiplier controller.
// No logic; latency n/a.
// No flow control; constants and the FSM state encoding only.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_W = 2;
    localparam int N_DIG   = 4;
    localparam int ACC_W   = 16;

endpackage

// File: rtl/mult8_seq_ctrl_if.sv
// Operand/result handshakes plus the digit bus to the external small core.
// No logic; latency n/a.
// valid/ready on both the operand and result sides; core path is combinational.
interface mult8_seq_ctrl_if
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = DIGIT_W * N_DIG,
    parameter int DIGIT = DIGIT_W
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [DIGIT-1:0]     core_a;
    logic [DIGIT-1:0]     core_b;
    logic [2*DIGIT-1:0]   core_p;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;

    // Source, sink and core side.
    modport master (
        output in_valid, a, b, core_p, out_ready,
        input  in_ready, core_a, core_b, out_valid, p
    );

    // Controller side.
    modport slave (
        input  in_valid, a, b, core_p, out_ready,
        output in_ready, core_a, core_b, out_valid, p
    );
endinterface

// File: rtl/mult_seq_acc.sv
// Shift-accumulate register: acc += zero-extended pp << shamt, modulo 2^ACC_W.
// One cycle from en to updated acc; clr wins over en.
// No backpressure; updates whenever en is high.
module mult_seq_acc
    import mult_seq_pkg::*;
#(
    parameter int ACC_W_P = ACC_W,
    parameter int PP_W    = 2 * DIGIT_W,
    parameter int SH_W    = $clog2(ACC_W_P)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [SH_W-1:0]    shamt,
    input  logic [PP_W-1:0]    pp,
    output logic [ACC_W_P-1:0] acc
);

    // Accumulator: clear on a new operation, otherwise add the shifted partial product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + (ACC_W_P'(pp) << shamt);
        end
    end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Multiplies two WIDTH-bit operands by walking all digit pairs through one external core.
// Accept to out_valid is N_DIG*N_DIG cycles (16); minimum initiation interval 18.
// in_ready only in IDLE; result held stable in DONE until out_ready.
module mult8_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = DIGIT_W * N_DIG,
    parameter int DIGIT = DIGIT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    mult8_seq_ctrl_if.slave  bus
);

    localparam int NUM_DIG = WIDTH / DIGIT;
    localparam int IDX_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int PW      = 2 * WIDTH;
    localparam int SH_W    = $clog2(PW);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIG - 1);

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [IDX_W-1:0]  i_idx;
    logic [IDX_W-1:0]  j_idx;
    logic              accept;
    logic              acc_en;
    logic [SH_W-1:0]   shamt;
    logic [PW-1:0]     acc;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshakes and core digit selection.
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        acc_en        = 1'b0;
        shamt         = '0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.core_a    = '0;
        bus.core_b    = '0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bus.core_a = a_reg[DIGIT*i_idx +: DIGIT];
                bus.core_b = b_reg[DIGIT*j_idx +: DIGIT];
                acc_en     = 1'b1;
                shamt      = SH_W'(DIGIT * (int'(i_idx) + int'(j_idx)));
                if (i_idx == LAST_IDX && j_idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (accept) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
        end
    end

    // Digit counters: j fastest, i advances when j wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_idx <= '0;
            j_idx <= '0;
        end else if (accept) begin
            i_idx <= '0;
            j_idx <= '0;
        end else if (state == RUN) begin
            if (j_idx == LAST_IDX) begin
                j_idx <= '0;
                i_idx <= (i_idx == LAST_IDX) ? '0 : i_idx + 1'b1;
            end else begin
                j_idx <= j_idx + 1'b1;
            end
        end
    end

    mult_seq_acc #(
        .ACC_W_P (PW),
        .PP_W    (2 * DIGIT),
        .SH_W    (SH_W)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (acc_en),
        .shamt (shamt),
        .pp    (bus.core_p),
        .acc   (acc)
    );

    assign bus.p = acc;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Bench for mult8_seq_ctrl with an exact 2x2 core or a constant-0xF stub core.
// Table vectors, randomized operands against a digit-sum model, and handshake/reset sequences.
// Source and sink are driven directly from the initial block.
module tb_mult8_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    bit   stub_core;

    always #5 clk = ~clk;

    mult8_seq_ctrl_if #(.WIDTH(8), .DIGIT(2)) bus ();

    // External core: exact 2x2 product or a constant stub.
    always_comb begin
        if (stub_core) bus.core_p = 4'hF;
        else           bus.core_p = {2'b00, bus.core_a} * {2'b00, bus.core_b};
    end

    mult8_seq_ctrl #(.WIDTH(8), .DIGIT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Product as the sum of all digit-pair products weighted by 4^(i+j), modulo 2^16.
    function automatic logic [15:0] model(input logic [7:0] av, input logic [7:0] bv, input bit stub);
        int sum = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                int da = (int'(av) >> (2 * i)) % 4;
                int db = (int'(bv) >> (2 * j)) % 4;
                int pp = stub ? 15 : da * db;
                sum += pp * (1 << (2 * (i + j)));
            end
        end
        return 16'(sum % 65536);
    endfunction

    // One full operation: offer operands, measure latency, take the result.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          output logic [15:0] res, output int lat);
        int w = 0;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        bus.a = av;
        bus.b = bv;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        res = bus.p;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        bit          stub;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [15:0] res;
        int          lat;

        vt[0] = '{8'h12, 8'h34, 1'b0, 16'h03A8};
        vt[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vt[2] = '{8'h00, 8'hA5, 1'b0, 16'h0000};
        vt[3] = '{8'h5A, 8'h3C, 1'b1, 16'hA757};
        vt[4] = '{8'h80, 8'h02, 1'b0, 16'h0100};
        vt[5] = '{8'h01, 8'h01, 1'b0, 16'h0001};

        rst_n         = 1'b0;
        stub_core     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_p",         32'(bus.p),         32'd0);
        check("rst_core_a",    32'(bus.core_a),    32'd0);
        check("rst_core_b",    32'(bus.core_b),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table vectors.
        for (int k = 0; k < 6; k++) begin
            stub_core = vt[k].stub;
            run_op(vt[k].a, vt[k].b, res, lat);
            check($sformatf("vec%0d_p", k),   32'(res), 32'(vt[k].exp));
            check($sformatf("vec%0d_lat", k), 32'(lat), 32'd16);
        end

        // Randomized operands against the model.
        for (int k = 0; k < 20; k++) begin
            logic [7:0] av;
            logic [7:0] bv;
            av = 8'($urandom_range(0, 255));
            bv = 8'($urandom_range(0, 255));
            stub_core = (k % 5 == 4);
            run_op(av, bv, res, lat);
            check($sformatf("rand%0d_p", k), 32'(res), 32'(model(av, bv, stub_core)));
        end
        stub_core = 1'b0;

        // Back-to-back with in_valid and out_ready held high.
        begin
            int acc_cyc[2];
            int n_acc = 0;
            int n_res = 0;
            int bad   = 0;
            bit busy  = 0;
            logic [15:0] r[2];
            bus.a = 8'h07;
            bus.b = 8'h09;
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            for (int c = 0; c < 80; c++) begin
                bit acc_now;
                acc_now = bus.in_valid && bus.in_ready;
                if (busy && bus.in_ready) bad++;
                if (bus.out_valid && bus.out_ready && n_res < 2) begin
                    r[n_res] = bus.p;
                    n_res++;
                    busy = 0;
                end
                if (acc_now && n_acc < 2) begin
                    acc_cyc[n_acc] = c;
                    busy = 1;
                end
                @(posedge clk); #1;
                if (acc_now) begin
                    n_acc++;
                    if (n_acc == 1) begin
                        bus.a = 8'hC3;
                        bus.b = 8'h5E;
                    end else begin
                        bus.in_valid = 1'b0;
                    end
                end
                if (n_res == 2) break;
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            check("b2b_results", 32'(n_res), 32'd2);
            check("b2b_accepts", 32'(n_acc), 32'd2);
            check("b2b_interval", 32'(acc_cyc[1] - acc_cyc[0]), 32'd18);
            check("b2b_in_ready_busy", 32'(bad), 32'd0);
            check("b2b_p0", 32'(r[0]), 32'd63);
            check("b2b_p1", 32'(r[1]), 32'(model(8'hC3, 8'h5E, 1'b0)));
        end

        // Sink stalls for 5 cycles after out_valid.
        begin
            int w   = 0;
            int bad = 0;
            bus.a = 8'h12;
            bus.b = 8'h34;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            while (!bus.out_valid && w < 100) begin
                @(posedge clk); #1; w++;
            end
            check("stall_lat", 32'(w), 32'd16);
            for (int k = 0; k < 5; k++) begin
                if (bus.out_valid !== 1'b1 || bus.p !== 16'h03A8 || bus.in_ready !== 1'b0) bad++;
                @(posedge clk); #1;
            end
            check("stall_stable", 32'(bad), 32'd0);
            check("stall_p_after", 32'(bus.p), 32'h03A8);
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            check("stall_release_out_valid", 32'(bus.out_valid), 32'd0);
            check("stall_release_in_ready",  32'(bus.in_ready),  32'd1);
        end

        // Reset pulsed during RUN cycle 7.
        begin
            int seen = 0;
            bus.a = 8'hE7;
            bus.b = 8'hB9;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            repeat (6) begin
                @(posedge clk); #1;
            end
            check("midrun_core_busy", 32'(bus.in_ready), 32'd0);
            rst_n = 1'b0;
            #1;
            check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
            check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
            check("midrst_p",         32'(bus.p),         32'd0);
            check("midrst_core_a",    32'(bus.core_a),    32'd0);
            check("midrst_core_b",    32'(bus.core_b),    32'd0);
            repeat (2) begin
                @(posedge clk); #1;
                if (bus.out_valid) seen++;
            end
            @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (bus.out_valid) seen++;
            end
            check("midrst_no_out_valid", 32'(seen), 32'd0);
            run_op(8'd3, 8'd3, res, lat);
            check("post_rst_p",   32'(res), 32'd9);
            check("post_rst_lat", 32'(lat), 32'd16);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
